btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 3, number of independent button channels (index 0 = start, 1 = stop, 2 = inc in the stopwatch build).
REQ-002 Parameter DB_CYCLES, default 65535, number of clk cycles the synchronised input must stay stable before the debounced level changes; legal range 2..2^20.
REQ-003 Parameter HOLD_CYCLES, default 6000000 (0.5 s at 12 MHz), number of cycles the debounced level must stay high after a press before the first auto-repeat; must be at least 2.
REQ-004 Parameter REPEAT_CYCLES, default 1200000 (100 ms at 12 MHz), interval between auto-repeats while the button is held; range 2..HOLD_CYCLES.
REQ-005 clk  input  1  single system clock (12 MHz); all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 btn_in  input  N_BTN  raw asynchronous active-high button levels.
REQ-008 btn_level  output  N_BTN  debounced level per channel.
REQ-009 press_pulse  output  N_BTN  one-cycle pulse on each debounced rising edge.
REQ-010 release_pulse  output  N_BTN  one-cycle pulse on each debounced falling edge.
REQ-011 repeat_pulse  output  N_BTN  one-cycle pulse for each auto-repeat event.
REQ-012 evt_pulse  output  N_BTN  press_pulse OR repeat_pulse, registered.

Function
REQ-013 Each btn_in bit SHALL pass through a 2-flop synchroniser before any other use; channels SHALL be fully independent.
REQ-014 Debounce: when the synchronised value equals btn_level, the counter SHALL clear; otherwise it SHALL increment, and when it reaches DB_CYCLES-1, btn_level SHALL take the synchronised value and the counter SHALL clear.
REQ-015 Latency: a clean raw edge at cycle t SHALL change btn_level at cycle t+2+DB_CYCLES (±1 for metastability resolution).
REQ-016 A glitch shorter than DB_CYCLES synchronised cycles SHALL cause no change to any output; the counter SHALL restart from 0 on every bounce.
REQ-017 press_pulse and release_pulse SHALL assert in the same cycle btn_level changes and SHALL last exactly one cycle.
REQ-018 Each channel SHALL have a hold FSM with states IDLE, HOLD, REPEAT.
REQ-019 IDLE->HOLD on press; hold counter cleared.
REQ-020 HOLD->REPEAT when the hold counter reaches HOLD_CYCLES-1; repeat_pulse is asserted on that transition.
REQ-021 In REPEAT, repeat_pulse SHALL assert each time the interval counter reaches REPEAT_CYCLES-1; the counter then wraps to 0.
REQ-022 A release SHALL force any state to IDLE in the same cycle and clear all counters; no repeat_pulse SHALL occur in the release cycle or after it.
REQ-023 press_pulse and repeat_pulse SHALL never coincide on one channel; evt_pulse SHALL follow them by exactly one cycle.
REQ-024 Counter widths SHALL be the clog2 of the respective parameter; counters SHALL saturate and never wrap past their terminal value.

Reset
REQ-025 While rst=0: all outputs 0, synchronisers 0, counters 0, FSMs IDLE.
REQ-026 Reset asserted mid-hold or mid-debounce SHALL abort immediately, with no pulse emitted.
REQ-027 A button held through reset release SHALL produce press_pulse after the normal debounce latency.

Structure
REQ-028 The default parameter constants and FSM state encodings SHALL live in the shared package btn_cfg_pkg.
REQ-029 A single sub-module, btn_channel (synchroniser, debounce, hold FSM), SHALL be instantiated N_BTN times by a generate loop.
REQ-030 Target size: 150-300 lines of RTL in total.

Verification (DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-031 btn_in[0] rises cleanly at cycle 10 -> btn_level[0] and press_pulse[0] at cycle 16, press_pulse one cycle wide, other channels 0.
REQ-032 btn_in[1] pulses high for 3 cycles, then 2 low, then 3 high, then low -> all outputs on channel 1 stay 0.
REQ-033 btn_in[2] held 60 cycles after press -> repeat_pulse[2] 20 cycles after press_pulse, then every 8 cycles; evt_pulse[2] lags each pulse by one cycle.
REQ-034 btn_in[2] released 3 cycles before a repeat would fire -> release_pulse[2] asserted, no further repeat_pulse.
REQ-035 rst=0 asserted while channel 2 is in REPEAT -> all outputs 0 at once; btn still high at reset release -> press_pulse[2] 6 cycles later.
REQ-036 All three buttons pressed in the same cycle -> three simultaneous press_pulses, with independent, identical repeat timing.

Source files
------------

// File: rtl/btn_cfg_pkg.sv
// Shared defaults, hold-FSM state encoding and counter sizing helper for the button conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_cfg_pkg;

  // Defaults sized for a 12 MHz system clock
  localparam int unsigned DEF_N_BTN         = 3;
  localparam int unsigned DEF_DB_CYCLES     = 65535;
  localparam int unsigned DEF_HOLD_CYCLES   = 6000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES = 1200000;  // 100 ms

  // Per-channel auto-repeat state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_e;

  // Counter width for a count that runs 0..n-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release edges and hold/auto-repeat FSM.
// Latency: level/press/release 2+DB_CYCLES cycles after a clean raw edge; evt_pulse one cycle after press/repeat.
// Backpressure: none; pulses are single-cycle strobes and are never held or queued.
module btn_channel
  import btn_cfg_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic evt_pulse
);

  localparam int unsigned DB_W   = cnt_width(DB_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              evt_q, evt_d;
  logic              level_rise, level_fall;

  hold_state_e       state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              repeat_q;

  // Synchroniser, debounce counter and edge strobes: next-state logic
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = db_cnt_q;

    if (sync2_q == level_q) begin
      // Input agrees with the debounced level: any bounce restarts the count
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      // Only reached below DB_LAST, so the counter saturates at its terminal value
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    level_rise = level_d & ~level_q;
    level_fall = ~level_d & level_q;
    press_d    = level_rise;
    release_d  = level_fall;
    evt_d      = press_q | repeat_q;
  end

  // Synchroniser, debounce and edge-strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      evt_q     <= evt_d;
    end
  end

  // Hold/auto-repeat FSM; a release overrides every state in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (level_fall) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (level_rise) begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= '0;
              rep_cnt_q  <= '0;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              // First repeat fires on the HOLD->REPEAT transition itself
              state_q    <= ST_REPEAT;
              hold_cnt_q <= '0;
              rep_cnt_q  <= '0;
              repeat_q   <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rep_cnt_q == REP_LAST) begin
              rep_cnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign evt_pulse     = evt_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button conditioners: synchronise, debounce, edge pulses and hold auto-repeat.
// Latency: 2+DB_CYCLES cycles raw edge to level/press/release; evt_pulse one further cycle.
// Backpressure: none; all outputs are free-running registered strobes/levels.
module btn_conditioner
  import btn_cfg_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] evt_pulse
);

  // One fully independent channel per button bit
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .evt_pulse    (evt_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = 2 + DB;  // raw edge to debounced level change

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;
  logic [N-1:0] evt_pulse;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_BTN        (N),
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .evt_pulse    (evt_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected behaviour for a clean press driven at k=0 and released at k=r.
  // kind: 0 level, 1 press, 2 release, 3 repeat, 4 evt
  function automatic bit exp_bit(input int kind, input int k, input int r);
    int p;
    int rl;
    p  = LAT;
    rl = r + LAT;
    case (kind)
      0: return (k >= p) && (k < rl);
      1: return k == p;
      2: return k == rl;
      3: return (k >= p + HOLD) && (k < rl) && (((k - p - HOLD) % REP) == 0);
      4: return exp_bit(1, k - 1, r) | exp_bit(3, k - 1, r);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sel(input bit b, input logic [N-1:0] mask);
    return b ? 32'(mask) : 32'd0;
  endfunction

  task automatic check_all(input string tag, input logic [N-1:0] l, input logic [N-1:0] p,
                           input logic [N-1:0] rl, input logic [N-1:0] rp, input logic [N-1:0] e);
    check({tag, "_level"},   32'(btn_level),     32'(l));
    check({tag, "_press"},   32'(press_pulse),   32'(p));
    check({tag, "_release"}, 32'(release_pulse), 32'(rl));
    check({tag, "_repeat"},  32'(repeat_pulse),  32'(rp));
    check({tag, "_evt"},     32'(evt_pulse),     32'(e));
  endtask

  // Press the buttons in mask, release after r cycles, check every cycle until settled
  task automatic run_press(input logic [N-1:0] mask, input int r, input string tag);
    btn_in = btn_in | mask;
    for (int k = 1; k <= r + LAT + 4; k++) begin
      step();
      if (k == r) btn_in = btn_in & ~mask;
      check({tag, "_level"},   32'(btn_level),     sel(exp_bit(0, k, r), mask));
      check({tag, "_press"},   32'(press_pulse),   sel(exp_bit(1, k, r), mask));
      check({tag, "_release"}, 32'(release_pulse), sel(exp_bit(2, k, r), mask));
      check({tag, "_repeat"},  32'(repeat_pulse),  sel(exp_bit(3, k, r), mask));
      check({tag, "_evt"},     32'(evt_pulse),     sel(exp_bit(4, k, r), mask));
    end
    repeat (4) step();
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = '1;

    // Reset holds everything low even with buttons pressed
    repeat (3) step();
    check_all("reset", '0, '0, '0, '0, '0);
    btn_in = '0;
    step();
    rst = 1'b1;
    repeat (10) step();
    check_all("idle", '0, '0, '0, '0, '0);

    // Clean short press on start: level/press 6 cycles after drive, released before hold expires
    run_press(3'b001, 10, "ch0_short");

    // Bouncy input on stop: 3 high, 2 low, 3 high, low -> nothing
    for (int k = 0; k < 20; k++) begin
      btn_in[1] = (k < 3) || (k >= 5 && k < 8);
      step();
      check_all("ch1_glitch", '0, '0, '0, '0, '0);
    end
    btn_in = '0;
    repeat (4) step();

    // Long hold on inc: repeats at press+20, then every 8
    run_press(3'b100, 66, "ch2_hold");
    // Release 3 cycles before the third repeat would fire
    run_press(3'b100, 33, "ch2_rel_early");
    // Release landing exactly on a repeat slot suppresses that repeat
    run_press(3'b100, 36, "ch2_rel_on_rep");
    // All three pressed together behave identically
    run_press(3'b111, 40, "all");

    // Reset while in REPEAT, button still held through reset release
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 30; k++) step();
    check("pre_rst_level", 32'(btn_level), 32'(3'b100));
    rst = 1'b0;
    #1;
    check_all("rst_async", '0, '0, '0, '0, '0);
    repeat (2) step();
    check_all("rst_held", '0, '0, '0, '0, '0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_rst_level",  32'(btn_level),    sel(k >= LAT, 3'b100));
      check("post_rst_press",  32'(press_pulse),  sel(k == LAT, 3'b100));
      check("post_rst_repeat", 32'(repeat_pulse), 32'd0);
      check("post_rst_evt",    32'(evt_pulse),    sel(k == LAT + 1, 3'b100));
    end
    btn_in = '0;
    repeat (12) step();
    check_all("final_idle", '0, '0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

endmodule
